// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem request, one-entry decode buffer
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] dec_pc_inc,
    input  logic              dec_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                kill_q, kill_d;
    logic                dec_valid_q, dec_valid_d;
    logic [INST_W-1:0]   dec_inst_q, dec_inst_d;
    logic [ADDR_W-1:0]   dec_pc_q, dec_pc_d;
    logic                halted_q, halted_d;
    logic                can_issue;

    // A new request is only allowed when the buffer will be free by the time its word returns.
    assign can_issue = ~dec_valid_q | dec_ready;
    assign imem_req  = rst_n & (state_q == S_FETCH) & can_issue & ~redirect & ~halt;
    assign imem_addr = pc_q;

    assign dec_valid  = dec_valid_q;
    assign dec_inst   = dec_inst_q;
    assign dec_pc     = dec_pc_q;
    assign dec_pc_inc = dec_pc_q + ADDR_W'(1);
    assign halted     = halted_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        dec_valid_d = dec_valid_q & ~dec_ready;
        dec_inst_d  = dec_inst_q;
        dec_pc_d    = dec_pc_q;
        halted_d    = halted_q;

        if (state_q == S_HALTED) begin
            dec_valid_d = 1'b0;
        end else if (halt) begin
            state_d     = S_HALTED;
            dec_valid_d = 1'b0;
            halted_d    = 1'b1;
            kill_d      = 1'b0;
        end else if (redirect) begin
            pc_d        = redirect_pc;
            dec_valid_d = 1'b0;
            // An in-flight word belongs to the old path: drop it now or mark it for dropping.
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    kill_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                        kill_d  = 1'b0;
                        if (!kill_q) begin
                            dec_valid_d = 1'b1;
                            dec_inst_d  = imem_rdata;
                            dec_pc_d    = pc_q;
                            pc_d        = pc_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_inst_q  <= '0;
            dec_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            dec_valid_q <= dec_valid_d;
            dec_inst_q  <= dec_inst_d;
            dec_pc_q    <= dec_pc_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;

    logic        clk;
    logic        rst_n, rst2_n;
    logic        imem_req, imem_rvalid, dec_valid, dec_ready, redirect, halt, halted;
    logic [15:0] imem_addr, imem_rdata, dec_inst, dec_pc, dec_pc_inc, redirect_pc;
    logic        imem_req2, imem_rvalid2, dec_valid2, dec_ready2, redirect2, halt2, halted2;
    logic [15:0] imem_addr2, imem_rdata2, dec_inst2, dec_pc2, dec_pc_inc2, redirect_pc2;

    logic [15:0] mem [256];
    logic [15:0] pend_addr;
    int          pend_cnt;
    int          lat;
    int          checks;
    int          errors;
    logic [15:0] exp_inst [3];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_pc_inc(dec_pc_inc),
        .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .dec_valid(dec_valid2), .dec_inst(dec_inst2), .dec_pc(dec_pc2), .dec_pc_inc(dec_pc_inc2),
        .dec_ready(dec_ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .halt(halt2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend_cnt    = 0;
        pend_addr   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[pend_addr[7:0]];
            end else begin
                imem_rvalid = 1'b0;
            end
            if (pend_cnt != 0) pend_cnt--;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) begin
                pend_addr = imem_addr;
                pend_cnt  = lat;
            end
        end
    end

    initial begin
        logic        seen;
        logic [15:0] a2;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = '0;
        forever begin
            @(negedge clk);
            seen = imem_req2;
            a2   = imem_addr2;
            @(posedge clk);
            #1;
            imem_rvalid2 = seen;
            imem_rdata2  = a2 ^ 16'h5A5A;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lat    = 1;
        for (int i = 0; i < 256; i++) mem[i] = {8'hEE, 8'(i)};
        mem[0] = 16'h1101;
        mem[1] = 16'h2202;
        mem[2] = 16'h3303;
        exp_inst[0] = 16'h1101;
        exp_inst[1] = 16'h2202;
        exp_inst[2] = 16'h3303;
        rst_n = 1'b0; rst2_n = 1'b0;
        dec_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        dec_ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0; halt2 = 1'b0;

        tick(); tick(); smp();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_inst", dec_inst, 16'h0000);
        chk("rst_pc", dec_pc, 16'h0000);
        chk("rst_halted", halted, 1'b0);

        tick(); rst_n = 1'b1; smp();
        chk("t1_req0", imem_req, 1'b1);
        chk("t1_addr0", imem_addr, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick(); smp();
            chk("t1_gap_valid", dec_valid, 1'b0);
            chk("t1_gap_req", imem_req, 1'b0);
            tick();
            if (k == 2) dec_ready = 1'b0;
            smp();
            chk("t1_valid", dec_valid, 1'b1);
            chk("t1_inst", dec_inst, exp_inst[k]);
            chk("t1_pc", dec_pc, 16'(k));
            chk("t1_pc_inc", dec_pc_inc, 16'(k + 1));
            chk("t1_req", imem_req, (k != 2));
            chk("t1_addr", imem_addr, 16'(k + 1));
        end

        for (int i = 1; i < 5; i++) begin
            tick(); smp();
            chk("t2_valid", dec_valid, 1'b1);
            chk("t2_inst", dec_inst, 16'h3303);
            chk("t2_req", imem_req, 1'b0);
        end
        tick(); dec_ready = 1'b1; smp();
        chk("t2_req_resume", imem_req, 1'b1);
        chk("t2_addr_resume", imem_addr, 16'h0003);
        tick(); smp();
        chk("t2_drain", dec_valid, 1'b0);
        tick(); lat = 3; smp();
        chk("t2_valid3", dec_valid, 1'b1);
        chk("t2_inst3", dec_inst, 16'hEE03);
        chk("t2_pc3", dec_pc, 16'h0003);
        chk("t2_req4", imem_req, 1'b1);
        chk("t2_addr4", imem_addr, 16'h0004);

        tick(); redirect = 1'b1; redirect_pc = 16'h0040; smp();
        chk("t3_req_redir", imem_req, 1'b0);
        tick(); redirect = 1'b0; smp();
        chk("t3_addr", imem_addr, 16'h0040);
        chk("t3_req_wait", imem_req, 1'b0);
        tick(); smp();
        chk("t3_stale_valid", dec_valid, 1'b0);
        chk("t3_stale_req", imem_req, 1'b0);
        tick(); smp();
        chk("t3_req40", imem_req, 1'b1);
        chk("t3_addr40", imem_addr, 16'h0040);
        tick(); tick(); tick();
        tick(); lat = 1; smp();
        chk("t3_valid", dec_valid, 1'b1);
        chk("t3_inst", dec_inst, 16'hEE40);
        chk("t3_pc", dec_pc, 16'h0040);
        chk("t3_pc_inc", dec_pc_inc, 16'h0041);
        chk("t3_addr41", imem_addr, 16'h0041);

        tick(); redirect = 1'b1; redirect_pc = 16'h0040; smp();
        chk("t4_req", imem_req, 1'b0);
        tick(); redirect = 1'b0; smp();
        chk("t4_valid", dec_valid, 1'b0);
        chk("t4_req40", imem_req, 1'b1);
        chk("t4_addr40", imem_addr, 16'h0040);
        tick(); smp();
        chk("t4_wait_valid", dec_valid, 1'b0);
        tick(); lat = 3; smp();
        chk("t4_inst", dec_inst, 16'hEE40);
        chk("t4_pc", dec_pc, 16'h0040);
        chk("t4_addr41", imem_addr, 16'h0041);

        tick(); halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0077; smp();
        chk("t5_halted_pre", halted, 1'b0);
        tick(); halt = 1'b0; redirect = 1'b0; smp();
        chk("t5_halted", halted, 1'b1);
        chk("t5_req", imem_req, 1'b0);
        chk("t5_valid", dec_valid, 1'b0);
        chk("t5_pc_frozen", imem_addr, 16'h0041);
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            chk("t5_hold_halted", halted, 1'b1);
            chk("t5_hold_valid", dec_valid, 1'b0);
            chk("t5_hold_req", imem_req, 1'b0);
            chk("t5_hold_pc", imem_addr, 16'h0041);
        end
        tick(); rst_n = 1'b0; smp();
        chk("t5_rst_halted", halted, 1'b0);
        chk("t5_rst_addr", imem_addr, 16'h0000);
        chk("t5_rst_req", imem_req, 1'b0);
        tick(); rst_n = 1'b1; smp();
        chk("t5_restart_req", imem_req, 1'b1);

        tick(); rst2_n = 1'b1; smp();
        chk("t6_req", imem_req2, 1'b1);
        chk("t6_addr", imem_addr2, 16'hFFFF);
        tick(); tick(); smp();
        chk("t6_valid", dec_valid2, 1'b1);
        chk("t6_pc", dec_pc2, 16'hFFFF);
        chk("t6_inst", dec_inst2, 16'hA5A5);
        chk("t6_pc_inc", dec_pc_inc2, 16'h0000);
        chk("t6_addr_wrap", imem_addr2, 16'h0000);
        tick(); tick(); smp();
        chk("t6_pc_wrap", dec_pc2, 16'h0000);
        chk("t6_inst_wrap", dec_inst2, 16'h5A5A);
        chk("t6_pc_inc_wrap", dec_pc_inc2, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
